uart_avm_arbiter: RTL
=====================

// Module: uart_avm_arbiter
// PURPOSE
//  Sole Avalon-MM master for the RS-232 UART core. Shares it between an RX byte consumer (image load
//  path) and a TX byte producer (result send path). Polls STATUS, issues RX reads / TX writes,
//  arbitrates when both sides are ready, and presents simple valid/ready byte streams to the clients.
//  Sits between the UART core and the image loader / result sender; these blocks never touch avm_* directly.
// PARAMETERS
//  PRIO_RX  0   0: round-robin between RX and TX; 1: RX has fixed priority
//  CNT_W    21  width of byte counters (covers 480*800*2 = 768000 bytes)
// PORTS
//  avm_clk          in   1     clock (only clock)
//  avm_rst          in   1     reset, asynchronous, active-high
//  avm_address      out  5     UART register byte address (RX_BASE/TX_BASE/STATUS_BASE)
//  avm_read         out  1     Avalon read request
//  avm_readdata     in   32    Avalon read data
//  avm_write        out  1     Avalon write request
//  avm_writedata    out  32    Avalon write data, {24'b0, byte}
//  avm_waitrequest  in   1     slave stall; transfer completes on cycle with req=1 and waitrequest=0
//  rx_en            in   1     RX client wants bytes; 0 = never grant RX
//  rx_valid         out  1     rx_data holds an unconsumed byte
//  rx_data          out  8     received byte
//  rx_ready         in   1     consumer accepts byte (transfer = rx_valid & rx_ready)
//  tx_valid         in   1     TX client offers tx_data
//  tx_data          in   8     byte to transmit
//  tx_ready         out  1     1-cycle pulse: tx_data accepted this cycle
//  o_rx_count       out  CNT_W bytes delivered to RX client (wraps)
//  o_tx_count       out  CNT_W bytes written to TX_BASE (wraps)
//  o_busy           out  1     1 when state is S_RX or S_TX
// BEHAVIOUR
//  - All outputs registered. Reset values: avm_address=STATUS_BASE, avm_read=0, avm_write=0,
//    avm_writedata=0, rx_valid=0, rx_data=0, tx_ready=0, counters=0, o_busy=0, state=S_INIT, last_grant=TX.
//  - Bus rule: while avm_waitrequest=1, avm_address/read/write/writedata held unchanged. Never read & write together.
//  - FSM: S_INIT -> S_POLL next cycle (avm_read=1, address=STATUS_BASE).
//    S_POLL, on completion: rx_want = readdata[RX_OK_BIT] & rx_en & !rx_valid;
//      tx_want = readdata[TX_OK_BIT] & tx_valid.
//      Both: PRIO_RX=1 -> RX; else grant the side != last_grant. One: grant it. None: stay S_POLL, read re-issued back-to-back.
//    Grant RX -> S_RX next cycle: address=RX_BASE, read=1.
//    Grant TX -> tx_ready=1 in the same cycle; tx_data latched into avm_writedata.
//      S_TX next cycle: address=TX_BASE, write=1, read=0.
//    S_RX completion: rx_data<=readdata[7:0], rx_valid<=1, o_rx_count+1, -> S_POLL.
//    S_TX completion: o_tx_count+1, write=0, -> S_POLL (read=1, address=STATUS_BASE).
//    last_grant updated on every grant.
//  - Latency: STATUS completion -> RX/TX request asserted 1 cycle later. RX completion -> rx_valid 1 cycle later.
//  - rx_valid clears on the cycle after rx_valid&rx_ready. Single-entry buffer: no RX grant while full.
//    A full buffer backpressures the UART FIFO and never drops a byte.
//  - rx_en falling during S_RX: read completes; byte still delivered.
//  - tx_valid falling after tx_ready: no effect, byte already latched.
//  - Reset mid-transaction: aborted immediately, all outputs to reset values, no byte counted.
//  - Counters wrap modulo 2^CNT_W.
// STRUCTURE
//  Shared package uart_pkg: RX_BASE=0, TX_BASE=4, STATUS_BASE=8, TX_OK_BIT=6, RX_OK_BIT=7,
//  enum state_t {S_INIT,S_POLL,S_RX,S_TX}.
//  Single module; no sub-module (arbitration is a 2-way pick on last_grant).
// TESTING
//  1 Reset, UART model STATUS=0x00 -> continuous STATUS reads at address 8, no RX/TX access, o_busy=0.
//  2 rx_en=1, STATUS=0x80, RX byte 0xA5, waitrequest=1 for 3 cycles -> read at 0 held stable,
//    rx_data=0xA5, rx_valid=1, o_rx_count=1.
//  3 tx_valid=1, tx_data=0x3C, STATUS=0x40 -> one tx_ready pulse, write at 4 with writedata=0x3C, o_tx_count=1.
//  4 PRIO_RX=0, STATUS=0xC0 constant, rx_ready=1, tx_valid=1 -> grants alternate RX,TX,RX,TX.
//    After 8 grants: rx_count=4, tx_count=4.
//  5 rx_ready=0 with rx_valid=1, STATUS=0x80 -> no further RX reads; rx_data unchanged
//    until rx_ready=1, then next byte read.
//  6 Assert avm_rst during S_TX with waitrequest=1 -> avm_write=0, address=8, counters=0 next edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART register map and arbiter state types.
package uart_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;
    localparam int unsigned TX_OK_BIT  = 6;
    localparam int unsigned RX_OK_BIT  = 7;

    typedef enum logic [1:0] {S_INIT, S_POLL, S_RX, S_TX} state_t;
    typedef enum logic {G_RX, G_TX} grant_t;

endpackage

// File: rtl/uart_avm_arbiter_if.sv
// Avalon-MM bus between the arbiter (master) and the UART core (slave).
interface uart_avm_arbiter_if;

    logic [4:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/uart_avm_arbiter.sv
// Sole Avalon-MM master of the UART: polls STATUS and shares the core between an RX byte
// consumer and a TX byte producer.
module uart_avm_arbiter
    import uart_pkg::*;
#(
    parameter bit          PRIO_RX = 1'b0,
    parameter int unsigned CNT_W   = 21
) (
    input  logic                 avm_clk,
    input  logic                 avm_rst,
    uart_avm_arbiter_if.master   avm,
    input  logic                 rx_en,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    input  logic                 rx_ready,
    input  logic                 tx_valid,
    input  logic [7:0]           tx_data,
    output logic                 tx_ready,
    output logic [CNT_W-1:0]     o_rx_count,
    output logic [CNT_W-1:0]     o_tx_count,
    output logic                 o_busy
);

    state_t             state_q, state_d;
    grant_t             last_grant_q, last_grant_d;
    logic [4:0]         address_q, address_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [31:0]        writedata_q, writedata_d;
    logic               rx_valid_q, rx_valid_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               tx_ready_q, tx_ready_d;
    logic [CNT_W-1:0]   rx_count_q, rx_count_d;
    logic [CNT_W-1:0]   tx_count_q, tx_count_d;
    logic               busy_q, busy_d;

    logic done, rx_want, tx_want, grant_rx, grant_tx;
    logic unused_readdata;

    assign unused_readdata = ^{avm.readdata[31:8], avm.readdata[5:0]};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        tx_ready_d   = 1'b0;
        rx_count_d   = rx_count_q;
        tx_count_d   = tx_count_q;
        rx_want      = 1'b0;
        tx_want      = 1'b0;
        grant_rx     = 1'b0;
        grant_tx     = 1'b0;
        done         = (read_q | write_q) & ~avm.waitrequest;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_INIT: begin
                state_d   = S_POLL;
                read_d    = 1'b1;
                address_d = STATUS_BASE;
            end
            S_POLL: begin
                if (done) begin
                    // A full RX buffer holds bytes back in the UART FIFO rather than dropping them.
                    rx_want = avm.readdata[RX_OK_BIT] & rx_en & ~rx_valid_q;
                    tx_want = avm.readdata[TX_OK_BIT] & tx_valid;
                    if (rx_want && tx_want) begin
                        if (PRIO_RX || last_grant_q == G_TX) grant_rx = 1'b1;
                        else                                 grant_tx = 1'b1;
                    end else begin
                        grant_rx = rx_want;
                        grant_tx = tx_want;
                    end
                    if (grant_rx) begin
                        state_d      = S_RX;
                        address_d    = RX_BASE;
                        last_grant_d = G_RX;
                    end else if (grant_tx) begin
                        state_d      = S_TX;
                        address_d    = TX_BASE;
                        read_d       = 1'b0;
                        write_d      = 1'b1;
                        writedata_d  = {24'b0, tx_data};
                        tx_ready_d   = 1'b1;
                        last_grant_d = G_TX;
                    end
                end
            end
            S_RX: begin
                if (done) begin
                    rx_data_d  = avm.readdata[7:0];
                    rx_valid_d = 1'b1;
                    rx_count_d = rx_count_q + CNT_W'(1);
                    address_d  = STATUS_BASE;
                    state_d    = S_POLL;
                end
            end
            S_TX: begin
                if (done) begin
                    tx_count_d = tx_count_q + CNT_W'(1);
                    write_d    = 1'b0;
                    read_d     = 1'b1;
                    address_d  = STATUS_BASE;
                    state_d    = S_POLL;
                end
            end
            default: state_d = S_INIT;
        endcase

        busy_d = (state_d == S_RX) || (state_d == S_TX);
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q      <= S_INIT;
            last_grant_q <= G_TX;
            address_q    <= STATUS_BASE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            tx_ready_q   <= 1'b0;
            rx_count_q   <= '0;
            tx_count_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            tx_ready_q   <= tx_ready_d;
            rx_count_q   <= rx_count_d;
            tx_count_q   <= tx_count_d;
            busy_q       <= busy_d;
        end
    end

    assign avm.address   = address_q;
    assign avm.read      = read_q;
    assign avm.write     = write_q;
    assign avm.writedata = writedata_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign tx_ready      = tx_ready_q;
    assign o_rx_count    = rx_count_q;
    assign o_tx_count    = tx_count_q;
    assign o_busy        = busy_q;

endmodule
